// File: rtl/xbar_out_port_scheduler_if.sv
// Handshake bundle between crossbar inputs, one output-port scheduler and its output mux.
// The master side drives requests and beats; the scheduler (slave) returns grant and status.
interface xbar_out_port_scheduler_if #(
   parameter int N_IN = 4,
   parameter int ID_W = 2
);
   logic [N_IN-1:0]      req;
   logic [N_IN*ID_W-1:0] dest;
   logic [N_IN-1:0]      valid;
   logic [N_IN-1:0]      last;
   logic                 out_ready;
   logic [N_IN-1:0]      grant;
   logic [ID_W-1:0]      grant_idx;
   logic                 busy;
   logic                 xfer;
   logic                 timeout_err;

   modport master (
      output req, dest, valid, last, out_ready,
      input  grant, grant_idx, busy, xfer, timeout_err
   );

   modport slave (
      input  req, dest, valid, last, out_ready,
      output grant, grant_idx, busy, xfer, timeout_err
   );
endinterface

// File: rtl/xbar_out_port_scheduler.sv
// Round-robin packet scheduler for one crossbar output port; grant is held for a whole packet.
// Optional stall watchdog enabled by defining XBAR_SCHED_WATCHDOG_EN.
module xbar_out_port_scheduler #(
   parameter int N_IN    = 4,
   parameter int ID_W    = 2,
   parameter int PORT_ID = 0,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input logic                    clk,
   input logic                    reset,
   xbar_out_port_scheduler_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] grant_idx_q, grant_idx_d;
   logic [N_IN-1:0] grant_q, grant_d;
   logic            timeout_err_q, timeout_err_d;

   logic [N_IN-1:0] eligible;
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] pick_idx;
   logic            pick_found;
   logic            busy;
   logic            xfer;
   logic            rel_normal;
   logic            wd_fire;

   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         eligible[i] = bus.req[i] && (bus.dest[i*ID_W +: ID_W] == ID_W'(PORT_ID));
      end
   end

   // Scan starts just past the last winner, so the previous owner ranks lowest.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= N_IN; k++) begin
         cand = ID_W'((int'(ptr_q) + k) % N_IN);
         if (!pick_found && eligible[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign busy       = (state_q == GRANT);
   assign xfer       = busy && bus.valid[grant_idx_q] && bus.out_ready;
   assign rel_normal = busy && ((xfer && bus.last[grant_idx_q]) || !bus.req[grant_idx_q]);

`ifdef XBAR_SCHED_WATCHDOG_EN
   logic [TO_W-1:0] wd_cnt_q, wd_cnt_d;

   // Counter reads 0 in the first GRANT cycle, so release lands after exactly TIMEOUT stalls.
   always_comb begin
      wd_cnt_d = '0;
      if (busy && !xfer) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   assign wd_fire = busy && !xfer && (wd_cnt_q == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

   // NOTE: every variable gets a default before the case, otherwise a missed branch infers a latch.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_d       = grant_q;
      grant_idx_d   = grant_idx_q;
      timeout_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d     = GRANT;
               grant_d     = N_IN'(1) << pick_idx;
               grant_idx_d = pick_idx;
            end
         end
         GRANT: begin
            if (rel_normal || wd_fire) begin
               state_d       = IDLE;
               ptr_d         = grant_idx_q;
               grant_d       = '0;
               timeout_err_d = wd_fire && !rel_normal;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= ID_W'(N_IN - 1);
         grant_q       <= '0;
         grant_idx_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_q       <= grant_d;
         grant_idx_q   <= grant_idx_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = grant_idx_q;
   assign bus.busy        = busy;
   assign bus.xfer        = xfer;
   assign bus.timeout_err = timeout_err_q;

endmodule
